blur_mem_arbiter: RTL and testbench

- Shares one single-port blur-image SRAM (480 rows x 5120 bits, 1-cycle read latency) between NUM_REQ requesters.
- Requesters are: 0 = Gaussian writer, 1 = keypoint detector, 2 = descriptor line-buffer fill.
- Grants whole row bursts in round-robin order and drives the SRAM address, write-enable and data pins.
- Returns read data tagged per requester.
- CORE instantiates one arbiter per blur memory, replacing the per-state address mux.

---
 rtl/sift_mem_pkg.sv | 20 ++
 rtl/blur_mem_arbiter_rr_picker.sv | 36 +++
 rtl/blur_mem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_blur_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sift_mem_pkg.sv
// Shared constants, requester indices and arbiter state encoding for the blur-image memories.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sift_mem_pkg;

    localparam int BLUR_ROWS   = 480;
    localparam int BLUR_ADDR_W = 9;
    localparam int ROW_W       = 5120;

    // Requester slots on every blur-memory arbiter
    localparam int REQ_GAUSS  = 0;
    localparam int REQ_DETECT = 1;
    localparam int REQ_DESC   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/blur_mem_arbiter_rr_picker.sv
// Round-robin one-hot picker: first set req scanning ptr, ptr+1, ... modulo NUM_REQ.
// Latency: combinational.
// Backpressure: none; onehot is all-zero when no req is set.
// Ports: req (request vector), ptr (highest-priority index), onehot/index (winner).
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   index
);

    logic found;
    int   cand;

    always_comb begin
        onehot = '0;
        index  = '0;
        found  = 1'b0;
        cand   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req[cand]) begin
                found        = 1'b1;
                onehot[cand] = 1'b1;
                index        = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/blur_mem_arbiter.sv
// Round-robin row-burst arbiter sharing one single-port blur SRAM between NUM_REQ requesters.
// Latency: req seen in IDLE -> gnt and first beat next cycle; read data tagged one cycle after each read beat.
// Backpressure: none inside a burst; losers hold req until granted, one idle turnaround between bursts.
// Ports: req/req_we/req_base/req_len in, gnt/done/wr_ack/rd_valid/rd_data out, mem_* to the SRAM.
// Optional BLUR_ARB_STATS_EN adds saturating busy_cycles / wait_cycles counters.
module blur_mem_arbiter
    import sift_mem_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ROWS    = BLUR_ROWS,
    parameter int ADDR_W  = BLUR_ADDR_W,
    parameter int DATA_W  = ROW_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_base,
    input  logic [NUM_REQ*ADDR_W-1:0] req_len,
    input  logic [DATA_W-1:0]         wr_data,
    output logic                      wr_ack,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_din,
    input  logic [DATA_W-1:0]         mem_dout
`ifdef BLUR_ARB_STATS_EN
    ,
    output logic [31:0]               busy_cycles,
    output logic [NUM_REQ*32-1:0]     wait_cycles
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    win_q, win_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [ADDR_W-1:0]   row_q, row_d;
    logic [ADDR_W-1:0]   beat_q, beat_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic                we_q, we_d;
    logic [NUM_REQ-1:0]  rd_valid_q, rd_valid_d;

    logic [NUM_REQ-1:0]  pick_onehot;
    logic [IDX_W-1:0]    pick_idx;
    logic [ADDR_W-1:0]   sel_base;
    logic [ADDR_W-1:0]   sel_len;
    logic                last_beat;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req     (req),
        .ptr     (ptr_q),
        .onehot  (pick_onehot),
        .index   (pick_idx)
    );

    assign last_beat = (state_q == ST_BURST) && (beat_q == len_q);

    always_comb begin
        sel_base = '0;
        sel_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_base = req_base[i*ADDR_W +: ADDR_W];
                sel_len  = req_len[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        gnt_d      = gnt_q;
        row_d      = row_q;
        beat_d     = beat_q;
        len_d      = len_q;
        we_d       = we_q;
        rd_valid_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_BURST;
                    gnt_d   = pick_onehot;
                    win_d   = pick_idx;
                    row_d   = sel_base;
                    len_d   = sel_len;
                    beat_d  = '0;
                    // Only the Gaussian writer may write; everyone else reads.
                    we_d    = (pick_idx == IDX_W'(REQ_GAUSS)) && req_we[pick_idx];
                end
            end
            ST_BURST: begin
                rd_valid_d = we_q ? '0 : gnt_q;
                if (beat_q == len_q) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    ptr_d   = (win_q == IDX_W'(NUM_REQ-1)) ? '0 : win_q + IDX_W'(1);
                end else begin
                    // row_q is left on the last issued row so mem_addr holds in IDLE
                    beat_d = beat_q + ADDR_W'(1);
                    row_d  = (row_q == ADDR_W'(ROWS-1)) ? '0 : row_q + ADDR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            win_q      <= '0;
            gnt_q      <= '0;
            row_q      <= '0;
            beat_q     <= '0;
            len_q      <= '0;
            we_q       <= 1'b0;
            rd_valid_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            gnt_q      <= gnt_d;
            row_q      <= row_d;
            beat_q     <= beat_d;
            len_q      <= len_d;
            we_q       <= we_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign gnt      = gnt_q;
    assign done     = last_beat ? gnt_q : '0;
    assign mem_we   = (state_q == ST_BURST) && we_q;
    assign wr_ack   = mem_we;
    assign mem_addr = row_q;
    assign mem_din  = wr_data;
    assign rd_valid = rd_valid_q;
    assign rd_data  = mem_dout;

`ifdef BLUR_ARB_STATS_EN
    logic [31:0]              busy_q, busy_d;
    logic [NUM_REQ-1:0][31:0] wait_q, wait_d;

    always_comb begin
        busy_d = busy_q;
        wait_d = wait_q;
        if ((state_q == ST_BURST) && (busy_q != '1)) begin
            busy_d = busy_q + 32'd1;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && !gnt_q[i] && (wait_q[i] != '1)) begin
                wait_d[i] = wait_q[i] + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            wait_q <= '0;
        end else begin
            busy_q <= busy_d;
            wait_q <= wait_d;
        end
    end

    assign busy_cycles = busy_q;
    assign wait_cycles = wait_q;
`endif

endmodule

// File: tb/tb_blur_mem_arbiter.sv
module tb_blur_mem_arbiter;

    localparam int ROWS = 480;
    localparam int NR   = 3;
    localparam int AW   = 9;
    localparam int DW   = 5120;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR-1:0]     req_we;
    logic [NR*AW-1:0]  req_base;
    logic [NR*AW-1:0]  req_len;
    logic [DW-1:0]     wr_data;
    logic              wr_ack;
    logic [NR-1:0]     gnt;
    logic [NR-1:0]     done;
    logic [NR-1:0]     rd_valid;
    logic [DW-1:0]     rd_data;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_din;
    logic [DW-1:0]     mem_dout;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state kept by the bench
    int            ptr_m;
    int            prev_addr;
    logic [DW-1:0] exp_mem [ROWS];
    logic [DW-1:0] sram    [ROWS];

    blur_mem_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_we   (req_we),
        .req_base (req_base),
        .req_len  (req_len),
        .wr_data  (wr_data),
        .wr_ack   (wr_ack),
        .gnt      (gnt),
        .done     (done),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input int r);
        logic [31:0] w;
        w = 32'(r) * 32'h9E37_79B1 ^ 32'h5A5A_0000;
        return {160{w}};
    endfunction

    // Single-port SRAM with one-cycle read latency; rows re-seeded on reset
    always @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) sram[r] <= pat(r);
        end else begin
            if (mem_we) sram[mem_addr] <= mem_din;
            mem_dout <= sram[mem_addr];
        end
    end

    function automatic int pick(input logic [NR-1:0] r, input int p);
        for (int k = 0; k < NR; k++) begin
            if (r[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_data(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed low64 %0h expected low64 %0h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    task automatic rand_wr();
        for (int i = 0; i < DW/32; i++) wr_data[i*32 +: 32] = $urandom;
    endtask

    task automatic init_model();
        for (int r = 0; r < ROWS; r++) exp_mem[r] = pat(r);
        ptr_m     = 0;
        prev_addr = 0;
    endtask

    task automatic set_slot(input int i, input int base, input int len);
        req_base[i*AW +: AW] = AW'(base);
        req_len[i*AW +: AW]  = AW'(len);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_gnt"}, gnt, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_wr_ack"}, wr_ack, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
    endtask

    // Called at a negedge with the DUT idle and the request inputs already applied.
    // Follows the winning burst beat by beat, then the turnaround cycle.
    task automatic run_burst(input bit perturb);
        int w, base, len, a;
        bit we;
        w    = pick(req, ptr_m);
        base = int'(req_base[w*AW +: AW]);
        len  = int'(req_len[w*AW +: AW]);
        we   = (w == 0) && req_we[w];
        for (int k = 0; k <= len; k++) begin
            @(negedge clk);
            if (we && k > 0) rand_wr();
            a = (base + k) % ROWS;
            chk("gnt", gnt, 64'(1) << w);
            chk("mem_addr", mem_addr, a);
            chk("mem_we", mem_we, we);
            chk("wr_ack", wr_ack, we);
            chk("done", done, (k == len) ? (64'(1) << w) : 0);
            if (k > 0 && !we) begin
                chk("rd_valid", rd_valid, 64'(1) << w);
                chk_data("rd_data", rd_data, exp_mem[prev_addr]);
            end else begin
                chk("rd_valid", rd_valid, 0);
            end
            if (we) begin
                chk_data("mem_din", mem_din, wr_data);
                exp_mem[a] = wr_data;
            end
            prev_addr = a;
            if (perturb) begin
                req    = 3'($urandom);
                req_we = 3'($urandom);
                for (int i = 0; i < NR; i++) set_slot(i, $urandom_range(0, ROWS-1), $urandom_range(0, 6));
            end
        end
        @(negedge clk);
        chk("ta_gnt", gnt, 0);
        chk("ta_done", done, 0);
        chk("ta_mem_we", mem_we, 0);
        chk("ta_wr_ack", wr_ack, 0);
        chk("ta_mem_addr", mem_addr, prev_addr);
        if (!we) begin
            chk("ta_rd_valid", rd_valid, 64'(1) << w);
            chk_data("ta_rd_data", rd_data, exp_mem[prev_addr]);
        end else begin
            chk("ta_rd_valid", rd_valid, 0);
        end
        ptr_m = (w + 1) % NR;
    endtask

    initial begin
        rst      = 1'b1;
        req      = '0;
        req_we   = '0;
        req_base = '0;
        req_len  = '0;
        rand_wr();
        init_model();
        repeat (2) @(negedge clk);
        chk_quiet("reset");
        chk("reset_mem_addr", mem_addr, 0);
        rst = 1'b0;

        // Round-robin with all three requesting single rows: 0, 1, 2, 0
        req = 3'b111;
        for (int i = 0; i < NR; i++) set_slot(i, 20 + i, 0);
        repeat (4) run_burst(1'b0);
        req = '0;

        // Single read burst from the detector
        req = 3'b010;
        set_slot(1, 10, 2);
        run_burst(1'b0);
        req = '0;

        // Single-row write from the Gaussian writer
        req    = 3'b001;
        req_we = 3'b001;
        set_slot(0, 0, 0);
        run_burst(1'b0);
        req    = '0;
        req_we = '0;

        // Row address wrap
        req = 3'b100;
        set_slot(2, 478, 3);
        run_burst(1'b0);

        // Write flag on a non-writer is a read
        req    = 3'b100;
        req_we = 3'b100;
        set_slot(2, 5, 1);
        run_burst(1'b0);
        req    = '0;
        req_we = '0;

        // Idle cycle: outputs quiet, address held
        @(negedge clk);
        chk_quiet("idle");
        chk("idle_mem_addr", mem_addr, prev_addr);

        // Randomised traffic, half the bursts with inputs disturbed mid-burst
        for (int it = 0; it < 160; it++) begin
            req    = 3'($urandom_range(0, 7));
            req_we = 3'($urandom);
            for (int i = 0; i < NR; i++) begin
                set_slot(i, ($urandom_range(0, 3) == 0) ? $urandom_range(470, ROWS-1)
                                                        : $urandom_range(0, ROWS-1),
                         $urandom_range(0, 6));
            end
            if (req == '0) begin
                @(negedge clk);
                chk_quiet("rnd_idle");
                chk("rnd_idle_mem_addr", mem_addr, prev_addr);
            end else begin
                run_burst(it[0]);
            end
        end

        // Leave the pointer away from 0 before the reset test
        req = 3'b010;
        set_slot(1, 30, 0);
        run_burst(1'b0);

        // Reset at beat 2 of a six-beat read
        req = 3'b010;
        set_slot(1, 100, 5);
        repeat (3) @(negedge clk);
        chk("pre_rst_gnt", gnt, 3'b010);
        chk("pre_rst_mem_addr", mem_addr, 102);
        rst = 1'b1;
        @(negedge clk);
        chk_quiet("mid_rst");
        chk("mid_rst_mem_addr", mem_addr, 0);
        rst = 1'b0;
        init_model();
        req = 3'b000;
        @(negedge clk);
        chk_quiet("post_rst");

        // Pointer back at 0: requester 0 beats requester 2
        req = 3'b101;
        set_slot(0, 40, 1);
        set_slot(2, 50, 1);
        run_burst(1'b0);
        req = '0;

        req = 3'b100;
        set_slot(2, 60, 0);
        run_burst(1'b0);
        req = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
